instruction_decode: RTL
=======================

// Module: instruction_decode
// PURPOSE
//  RV32I decode stage directly downstream of InstructionFetch.
//  - Consumes the fetch bundle (pc, inst) over a valid/ready handshake.
//  - Decodes register indices, immediate, opcode class and illegal flag.
//  - Presents the result to the execute stage through a registered valid/ready output.
//  - Holds a 2-entry skid buffer so io_if_ready is a registered signal.
// PARAMETERS
//  XLEN        32  datapath / pc width
//  ILEN        32  instruction width
//  SKID_DEPTH  2   output + skid entries; fixed, elaboration error if != 2
// PORTS
//  clock               in   1     single clock, rising edge
//  reset               in   1     synchronous, active-high
//  io_if_valid         in   1     fetch bundle valid
//  io_if_ready         out  1     decode can accept the bundle
//  io_if_bits_pc       in   XLEN  fetched pc
//  io_if_bits_inst     in   ILEN  fetched instruction
//  io_flush            in   1     execute-stage redirect; kills all in-flight bundles
//  io_ex_valid         out  1     decoded bundle valid
//  io_ex_ready         in   1     execute accepts the bundle
//  io_ex_bits_pc       out  XLEN  pc
//  io_ex_bits_inst     out  ILEN  raw instruction
//  io_ex_bits_opcode   out  7     inst[6:0]
//  io_ex_bits_funct3   out  3     inst[14:12]
//  io_ex_bits_rd       out  5     destination register; 0 for S/B types
//  io_ex_bits_rs1      out  5     inst[19:15]
//  io_ex_bits_rs2      out  5     inst[24:20]
//  io_ex_bits_imm      out  XLEN  sign-extended immediate (I/S/B/U/J); 0 for R type
//  io_ex_bits_illegal  out  1     unsupported opcode or inst[1:0] != 2'b11
//  io_redirected       out  1     early JAL redirect pulse; only with the macro, else tied 0
//  io_redirected_pc    out  XLEN  early redirect target; 0 when io_redirected is 0
// BEHAVIOUR
//  - Reset:
//    - io_ex_valid = 0, io_if_ready = 1, io_redirected = 0.
//    - All io_ex_bits_* = 0; both entries invalid.
//  - Latency: a bundle accepted at edge N is presented with io_ex_valid = 1 after edge N.
//    Full throughput of 1 bundle per cycle.
//  - Input handshake: transfer when io_if_valid && io_if_ready.
//    io_if_ready = !skid_valid, registered.
//  - Output register vs. skid entry:
//    - Output register stalled (io_ex_valid && !io_ex_ready) while a transfer occurs:
//      the bundle lands in the skid entry.
//    - Output drains: skid moves to the output register.
//    - Order is strictly preserved.
//  - Decode is combinational on the input. The decoded fields are stored, not recomputed.
//  - Legal opcodes: 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33, 0x0F, 0x73.
//    Any other opcode sets illegal = 1 and is still passed on.
//  - io_flush = 1:
//    - Both entries are cleared at the next edge.
//    - Any input transfer in that cycle is dropped.
//    - Flush overrides a simultaneous output handshake; execute ignores it.
//    - io_if_ready = 1 on the following cycle.
//  - Reset asserted mid-stream behaves as a flush and also clears the redirect state.
// CONFIGURATION
//  - Macro DECODE_JAL_REDIRECT_EN.
//  - Defined:
//    - A legal JAL (0x6F) accepted without flush pulses io_redirected for 1 cycle (the next one).
//    - io_redirected_pc = pc + J-imm, modulo 2^XLEN.
//    - Sets a wait_target flag.
//    - While wait_target = 1, input bundles with pc != target are accepted and discarded.
//    - The bundle with pc == target clears the flag and is decoded normally.
//    - io_flush clears wait_target.
//    - A JAL arriving while wait_target = 1 is discarded, so there are no nested redirects.
//  - Undefined: io_redirected = 0 and io_redirected_pc = 0; JAL passes through like any instruction.
// STRUCTURE
//  - Shared package decode_pkg:
//    - opcode localparams.
//    - imm_fmt_e enum (R, I, S, B, U, J).
//    - decoded_t struct (pc, inst, opcode, funct3, rd, rs1, rs2, imm, illegal).
//  - One sub-module inst_decoder:
//    - Purely combinational.
//    - Takes inst and returns decoded_t.
//    - Reused by the future register-read stage.
//  - Top level:
//    - Skid buffer of two decoded_t registers.
//    - Redirect logic under the macro.
// TESTING
//  1. addi x1,x0,5 (0x00500093), pc 0x0800_0000 -> one cycle later ex_valid=1, rd=1, rs1=0,
//     imm=5, illegal=0.
//  2. sw x2,8(x1) (0x0020A423) -> rd=0, rs1=1, rs2=2, imm=8.
//     sign check: imm=-4 gives imm=0xFFFF_FFFC.
//  3. Back-to-back stream, ex_ready=0 for 3 cycles:
//     - if_ready falls after the 2nd bundle is held.
//     - After release, all bundles emerge in order with none lost or duplicated.
//  4. io_flush with both entries full and if_valid=1:
//     - ex_valid=0 at the next edge and if_ready=1.
//     - The next bundle (pc 0x0800_0100) emerges first.
//  5. 0xFFFF_FFFF -> illegal=1, still delivered with its pc.
//  6. Macro defined: JAL x0,+0x100 (0x1000006F) at pc 0x0800_0000:
//     - 1-cycle io_redirected pulse with pc 0x0800_0100.
//     - Wrong-path pc 0x0800_0004 is dropped; pc 0x0800_0100 is decoded.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared RV32I decode types, opcode constants and format helpers
package decode_pkg;
  localparam int XLEN_D = 32;
  localparam int ILEN_D = 32;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;
  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic [ILEN_D-1:0] inst;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN_D-1:0] imm;
    logic              illegal;
  } decoded_t;
  function automatic logic legal_op(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM};
  endfunction
  // Unknown opcodes fall back to R so they carry a zero immediate.
  function automatic imm_fmt_e fmt_of(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC} ? FMT_U :
           op == OP_JAL ? FMT_J :
           op == OP_BRANCH ? FMT_B :
           op == OP_STORE ? FMT_S :
           op inside {OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM} ? FMT_I : FMT_R;
  endfunction
endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: purely combinational RV32I field and immediate decoder
module inst_decoder
  import decode_pkg::*;
(
  input  logic [XLEN_D-1:0] pc,
  input  logic [ILEN_D-1:0] inst,
  output decoded_t          dec
);
  imm_fmt_e fmt;
  logic [XLEN_D-1:0] imm;
  always_comb begin
    fmt = fmt_of(inst[6:0]);
    imm = fmt == FMT_I ? {{20{inst[31]}}, inst[31:20]} :
          fmt == FMT_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
          fmt == FMT_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
          fmt == FMT_U ? {inst[31:12], 12'b0} :
          fmt == FMT_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
          '0;
    dec.pc      = pc;
    dec.inst    = inst;
    dec.opcode  = inst[6:0];
    dec.funct3  = inst[14:12];
    dec.rd      = fmt inside {FMT_S, FMT_B} ? 5'd0 : inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.imm     = imm;
    dec.illegal = !legal_op(inst[6:0]) || inst[1:0] != 2'b11;
  end
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: RV32I decode stage with 2-entry skid buffer; DECODE_JAL_REDIRECT_EN adds early JAL redirect
module instruction_decode
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_if_valid,
  output logic            io_if_ready,
  input  logic [XLEN-1:0] io_if_bits_pc,
  input  logic [ILEN-1:0] io_if_bits_inst,
  input  logic            io_flush,
  output logic            io_ex_valid,
  input  logic            io_ex_ready,
  output logic [XLEN-1:0] io_ex_bits_pc,
  output logic [ILEN-1:0] io_ex_bits_inst,
  output logic [6:0]      io_ex_bits_opcode,
  output logic [2:0]      io_ex_bits_funct3,
  output logic [4:0]      io_ex_bits_rd,
  output logic [4:0]      io_ex_bits_rs1,
  output logic [4:0]      io_ex_bits_rs2,
  output logic [XLEN-1:0] io_ex_bits_imm,
  output logic            io_ex_bits_illegal,
  output logic            io_redirected,
  output logic [XLEN-1:0] io_redirected_pc
);
  if (SKID_DEPTH != 2 || XLEN != XLEN_D || ILEN != ILEN_D) begin : g_cfg_check
    $error("instruction_decode: SKID_DEPTH must be 2 and XLEN/ILEN must be 32");
  end
  decoded_t dec, out_q, skid_q;
  logic out_v, skid_v, xfer, keep, drop;
  inst_decoder u_dec (.pc(io_if_bits_pc), .inst(io_if_bits_inst), .dec(dec));
  assign io_if_ready = !skid_v;
  assign xfer = io_if_valid && io_if_ready && !io_flush;
  assign keep = xfer && !drop;
  // Skid only fills while the output is stalled, so a free output drains it first.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (io_flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_v && !io_ex_ready) begin
      if (keep) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end else if (skid_v) begin
      out_q  <= skid_q;
      out_v  <= 1'b1;
      skid_v <= 1'b0;
    end else begin
      out_v <= keep;
      if (keep) out_q <= dec;
    end
  end
  assign io_ex_valid        = out_v;
  assign io_ex_bits_pc      = out_q.pc;
  assign io_ex_bits_inst    = out_q.inst;
  assign io_ex_bits_opcode  = out_q.opcode;
  assign io_ex_bits_funct3  = out_q.funct3;
  assign io_ex_bits_rd      = out_q.rd;
  assign io_ex_bits_rs1     = out_q.rs1;
  assign io_ex_bits_rs2     = out_q.rs2;
  assign io_ex_bits_imm     = out_q.imm;
  assign io_ex_bits_illegal = out_q.illegal;
`ifdef DECODE_JAL_REDIRECT_EN
  logic wait_q, redir_q, start;
  logic [XLEN-1:0] tgt_q, redir_pc_q, jal_tgt;
  assign jal_tgt = io_if_bits_pc + dec.imm;
  // While waiting for the jump target, wrong-path bundles are consumed but discarded.
  assign drop  = wait_q && io_if_bits_pc != tgt_q;
  assign start = keep && dec.opcode == OP_JAL && !dec.illegal;
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      wait_q     <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      wait_q     <= start || (wait_q && !keep);
      redir_q    <= start;
      redir_pc_q <= start ? jal_tgt : '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) tgt_q <= '0;
    else if (start) tgt_q <= jal_tgt;
  end
  assign io_redirected    = redir_q;
  assign io_redirected_pc = redir_pc_q;
`else
  assign drop             = 1'b0;
  assign io_redirected    = 1'b0;
  assign io_redirected_pc = '0;
`endif
endmodule
